block_memory_responder: RTL and testbench
=========================================

# block_memory_responder

Memory-side responder for the cache/main-memory block interface. Accepts one block read or block write from the data cache controller, holds BUSYWAIT high for a fixed access latency, then commits the write or returns the read block. Sits below the data cache as the backing store; it is the responder end of the cache's READ/WRITE/BUSYWAIT handshake.

## Interface
- ADDR_W, 6, block address width; DEPTH = 2**ADDR_W blocks
- BLOCK_W, 32, block width in bits (4 bytes)
- LATENCY, 5, access latency in cycles from acceptance to completion; legal range 1..15
- CLK  input  1  clock, all state on rising edge
- RESET  input  1  synchronous, active-low reset
- READ  input  1  block read request
- WRITE  input  1  block write request
- ADDRESS  input  ADDR_W  block address
- WRITEDATA  input  BLOCK_W  block to write
- READDATA  output  BLOCK_W  last completed read block
- BUSYWAIT  output  1  high while a request is pending or in service
- ERR  output  1  sticky; set on READ and WRITE both high in IDLE

One clock; reset is synchronous and active-low.

## Operation
- States: IDLE, BUSY, DONE (plus CLEAR under RESET_CLEAR_EN).
- IDLE, exactly one of READ/WRITE high: latch ADDRESS, WRITEDATA, op at the edge; load counter with LATENCY-1; go BUSY.
- IDLE, READ and WRITE both high: nothing accepted, no memory change, BUSYWAIT low, ERR set at edge; state stays IDLE.
- BUSY: counter decrements each edge; at the edge where counter==0: write latched data to mem[addr] (write) or load READDATA from mem[addr] (read); go DONE.
- DONE: one cycle, requests ignored, BUSYWAIT low; unconditionally to IDLE. Gives the requester one edge to drop READ/WRITE after BUSYWAIT falls.
- Inputs changing during BUSY/DONE are ignored; latched copies used.
- READDATA changes only on read completion or reset; writes never alter READDATA.
- ERR cleared only by reset.
- Counter width: 4 bits; LATENCY outside 1..15 is a configuration error.

## Timing
- BUSYWAIT = (IDLE & (READ ^ WRITE)) | BUSY (| CLEAR); combinational, so it rises in the same cycle the request is presented.
- Request accepted at edge T; completion at edge T+LATENCY; BUSYWAIT low from just after T+LATENCY; DONE for cycle T+LATENCY..T+LATENCY+1; next request earliest accepted at edge T+LATENCY+2.
- LATENCY=5: READ high in cycle before edge 0 -> READDATA valid after edge 5, BUSYWAIT low after edge 5.
- Reset values: READDATA=0, BUSYWAIT=0 (IDLE, no request), ERR=0, counter=0, state IDLE.
- Reset mid-BUSY: operation aborted at the reset edge, no memory write, READDATA=0, state IDLE (or CLEAR).
- Back-to-back address to the same block: write then read returns the written value.

## Configuration
- RESET_CLEAR_EN defined: reset enters CLEAR; one block zeroed per cycle, index 0..DEPTH-1; BUSYWAIT high throughout; requests ignored; after DEPTH cycles (edge at which index DEPTH-1 is written) go IDLE. Reset reasserted during CLEAR restarts at index 0.
- RESET_CLEAR_EN undefined: reset leaves memory contents unchanged; state goes directly to IDLE; memory initial contents unspecified (X) until written.

## Test plan
- Write 0xDEADBEEF to block 0x0A, LATENCY=5 -> BUSYWAIT high same cycle, low after 5th edge; then read 0x0A -> READDATA=0xDEADBEEF after 5 edges.
- READ held high across completion -> exactly one access, DONE cycle ignores it, next acceptance two edges after completion.
- READ and WRITE both high in IDLE -> ERR=1, BUSYWAIT=0, memory and READDATA unchanged; ERR stays 1 until reset.
- RESET low at edge T+2 of a write of 0x12345678 to block 0x03 -> block 0x03 unchanged, READDATA=0, BUSYWAIT low after release (undefined macro).
- ADDRESS/WRITEDATA changed to 0x3F/0x0 during BUSY of write 0xA5A5A5A5 to 0x01 -> block 0x01=0xA5A5A5A5, block 0x3F untouched.
- RESET_CLEAR_EN, DEPTH=64: after reset BUSYWAIT high 64 cycles; read of any block returns 0x00000000.

Source files
------------

// File: rtl/block_memory_responder.sv
// block_memory_responder
// Memory-side responder for the data cache block interface. Accepts one block
// read or write in IDLE, holds BUSYWAIT for LATENCY cycles, then commits the
// write or loads READDATA, spends one DONE cycle, and returns to IDLE.
// Optional feature: define RESET_CLEAR_EN to zero every block after reset
// (one block per cycle, BUSYWAIT held high) before requests are accepted.
module block_memory_responder #(
    parameter int ADDR_W  = 6,
    parameter int BLOCK_W = 32,
    parameter int LATENCY = 5
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               READ,
    input  logic               WRITE,
    input  logic [ADDR_W-1:0]  ADDRESS,
    input  logic [BLOCK_W-1:0] WRITEDATA,
    output logic [BLOCK_W-1:0] READDATA,
    output logic               BUSYWAIT,
    output logic               ERR
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("block_memory_responder: LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        CLEAR = 2'd3
    } state_t;

`ifdef RESET_CLEAR_EN
    localparam state_t RESET_STATE = CLEAR;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    logic [BLOCK_W-1:0] mem [DEPTH];

    state_t             state;
    state_t             state_next;
    logic [3:0]         cnt;
    logic [ADDR_W-1:0]  lat_addr;
    logic [BLOCK_W-1:0] lat_data;
    logic               lat_write;

    logic               accept;
    logic               complete;
    logic               err_set;

`ifdef RESET_CLEAR_EN
    logic [ADDR_W-1:0]  clr_idx;
    logic               clr_last;

    assign clr_last = (clr_idx == '1);
`endif

    // State register; reset lands in IDLE, or CLEAR when the clear sweep is built in
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode, handshake strobes and the combinational BUSYWAIT
    always_comb begin
        state_next = state;
        BUSYWAIT   = 1'b0;
        accept     = 1'b0;
        complete   = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (READ ^ WRITE) begin
                    accept     = 1'b1;
                    BUSYWAIT   = 1'b1;
                    state_next = BUSY;
                end else if (READ & WRITE) begin
                    err_set = 1'b1;
                end
            end
            BUSY: begin
                BUSYWAIT = 1'b1;
                if (cnt == 4'd0) begin
                    complete   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            CLEAR: begin
`ifdef RESET_CLEAR_EN
                BUSYWAIT = 1'b1;
                if (clr_last) begin
                    state_next = IDLE;
                end
`else
                state_next = IDLE;
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latch, latency counter, read return and sticky error flag
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            cnt       <= 4'd0;
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_write <= 1'b0;
            READDATA  <= '0;
            ERR       <= 1'b0;
        end else begin
            if (accept) begin
                cnt       <= CNT_LOAD;
                lat_addr  <= ADDRESS;
                lat_data  <= WRITEDATA;
                lat_write <= WRITE;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (complete && !lat_write) begin
                READDATA <= mem[lat_addr];
            end
            if (err_set) begin
                ERR <= 1'b1;
            end
        end
    end

`ifdef RESET_CLEAR_EN
    // Clear sweep index; restarts from block 0 whenever reset is asserted
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            clr_idx <= '0;
        end else if (state == CLEAR) begin
            clr_idx <= clr_idx + 1'b1;
        end
    end
`endif

    // Block storage; a reset edge suppresses any pending commit
    always_ff @(posedge CLK) begin
        if (RESET && complete && lat_write) begin
            mem[lat_addr] <= lat_data;
        end
`ifdef RESET_CLEAR_EN
        else if (RESET && state == CLEAR) begin
            mem[clr_idx] <= '0;
        end
`endif
    end

endmodule

// File: tb/tb_block_memory_responder.sv
// Self-checking bench for block_memory_responder (LATENCY=5, 64 x 32-bit blocks).
// Read expectations are pushed to a scoreboard queue when a read is issued and
// popped when BUSYWAIT falls at completion.
module tb_block_memory_responder;

    localparam int LAT = 5;

    logic        CLK;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [5:0]  ADDRESS;
    logic [31:0] WRITEDATA;
    logic [31:0] READDATA;
    logic        BUSYWAIT;
    logic        ERR;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [64];
    bit          valid [64];
    logic [31:0] exp_q [$];
    logic [31:0] last_read = 32'h0;

    block_memory_responder #(
        .ADDR_W (6),
        .BLOCK_W(32),
        .LATENCY(LAT)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .READ     (READ),
        .WRITE    (WRITE),
        .ADDRESS  (ADDRESS),
        .WRITEDATA(WRITEDATA),
        .READDATA (READDATA),
        .BUSYWAIT (BUSYWAIT),
        .ERR      (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Wait out the post-reset clear sweep and record the all-zero contents
    task automatic wait_clear(input string tag);
        int edges;
        edges = 0;
        while (BUSYWAIT === 1'b1 && edges < 200) begin
            tick();
            edges++;
        end
        total++;
        if (edges != 64) begin
            bad++;
            $display("FAIL %s clear_cycles: got %0d want 64", tag, edges);
        end
        for (int i = 0; i < 64; i++) begin
            model[i] = 32'h0;
            valid[i] = 1'b1;
        end
    endtask

    // One complete transaction: present, accept, wait for completion, DONE cycle
    task automatic do_op(input bit is_write, input logic [5:0] a, input logic [31:0] d,
                         input bit scramble, input string tag);
        int edges;
        logic [31:0] e;
        ADDRESS   = a;
        WRITEDATA = d;
        READ      = !is_write;
        WRITE     = is_write;
        #1;
        total++;
        if (BUSYWAIT !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_rise: got %b want 1", tag, BUSYWAIT);
        end
        if (is_write) begin
            model[a] = d;
            valid[a] = 1'b1;
        end else begin
            exp_q.push_back(model[a]);
        end
        tick();
        READ  = 1'b0;
        WRITE = 1'b0;
        if (scramble) begin
            ADDRESS   = 6'h3F;
            WRITEDATA = 32'h0;
        end
        edges = 0;
        while (BUSYWAIT === 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        total++;
        if (edges != LAT) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", tag, edges, LAT);
        end
        if (!is_write && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            last_read = e;
            total++;
            if (READDATA !== e) begin
                bad++;
                $display("FAIL %s readdata: got %h want %h", tag, READDATA, e);
            end
        end
        tick();
    endtask

    task automatic test_reset;
        RESET     = 1'b0;
        READ      = 1'b0;
        WRITE     = 1'b0;
        ADDRESS   = '0;
        WRITEDATA = '0;
        tick();
        tick();
        total++;
        if (READDATA !== 32'h0) begin
            bad++;
            $display("FAIL reset_readdata: got %h want 00000000", READDATA);
        end
        total++;
        if (ERR !== 1'b0) begin
            bad++;
            $display("FAIL reset_err: got %b want 0", ERR);
        end
`ifdef RESET_CLEAR_EN
        total++;
        if (BUSYWAIT !== 1'b1) begin
            bad++;
            $display("FAIL reset_busy: got %b want 1", BUSYWAIT);
        end
        RESET = 1'b1;
        wait_clear("reset");
        do_op(1'b0, 6'h00, 32'h0, 1'b0, "clear_rd0");
        do_op(1'b0, 6'h2B, 32'h0, 1'b0, "clear_rd2b");
        do_op(1'b0, 6'h3F, 32'h0, 1'b0, "clear_rd3f");
`else
        total++;
        if (BUSYWAIT !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy: got %b want 0", BUSYWAIT);
        end
        RESET = 1'b1;
        tick();
        total++;
        if (BUSYWAIT !== 1'b0) begin
            bad++;
            $display("FAIL idle_busy: got %b want 0", BUSYWAIT);
        end
`endif
    endtask

    task automatic test_write_read;
        do_op(1'b1, 6'h0A, 32'hDEADBEEF, 1'b0, "wr_0a");
        total++;
        if (READDATA !== last_read) begin
            bad++;
            $display("FAIL wr_keeps_readdata: got %h want %h", READDATA, last_read);
        end
        do_op(1'b0, 6'h0A, 32'h0, 1'b0, "rd_0a");
        do_op(1'b1, 6'h22, 32'h0BADF00D, 1'b0, "wr_22");
        do_op(1'b0, 6'h22, 32'h0, 1'b0, "rd_22");
    endtask

    task automatic test_hold_read;
        int edges;
        ADDRESS = 6'h0A;
        READ    = 1'b1;
        WRITE   = 1'b0;
        exp_q.push_back(model[6'h0A]);
        exp_q.push_back(model[6'h0A]);
        tick();
        edges = 0;
        while (BUSYWAIT === 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        total++;
        if (edges != LAT) begin
            bad++;
            $display("FAIL hold_first_latency: got %0d want %0d", edges, LAT);
        end
        total++;
        if (READDATA !== exp_q[0]) begin
            bad++;
            $display("FAIL hold_first_data: got %h want %h", READDATA, exp_q[0]);
        end
        void'(exp_q.pop_front());
        tick();
        total++;
        if (BUSYWAIT !== 1'b1) begin
            bad++;
            $display("FAIL hold_idle_busy: got %b want 1", BUSYWAIT);
        end
        edges = 0;
        while (BUSYWAIT === 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        total++;
        if (edges != LAT + 1) begin
            bad++;
            $display("FAIL hold_reaccept: got %0d want %0d", edges, LAT + 1);
        end
        last_read = exp_q.pop_front();
        total++;
        if (READDATA !== last_read) begin
            bad++;
            $display("FAIL hold_second_data: got %h want %h", READDATA, last_read);
        end
        READ = 1'b0;
        tick();
    endtask

    task automatic test_input_change;
        do_op(1'b1, 6'h3F, 32'h77777777, 1'b0, "wr_3f");
        do_op(1'b1, 6'h01, 32'hA5A5A5A5, 1'b1, "wr_01_scrambled");
        do_op(1'b0, 6'h01, 32'h0, 1'b0, "rd_01");
        do_op(1'b0, 6'h3F, 32'h0, 1'b0, "rd_3f_untouched");
    endtask

    task automatic test_err;
        READ      = 1'b1;
        WRITE     = 1'b1;
        ADDRESS   = 6'h0A;
        WRITEDATA = 32'h0;
        #1;
        total++;
        if (BUSYWAIT !== 1'b0) begin
            bad++;
            $display("FAIL err_busy: got %b want 0", BUSYWAIT);
        end
        tick();
        total++;
        if (ERR !== 1'b1) begin
            bad++;
            $display("FAIL err_set: got %b want 1", ERR);
        end
        total++;
        if (READDATA !== last_read) begin
            bad++;
            $display("FAIL err_readdata: got %h want %h", READDATA, last_read);
        end
        READ  = 1'b0;
        WRITE = 1'b0;
        tick();
        total++;
        if (BUSYWAIT !== 1'b0) begin
            bad++;
            $display("FAIL err_idle: got %b want 0", BUSYWAIT);
        end
        do_op(1'b0, 6'h0A, 32'h0, 1'b0, "err_mem_unchanged");
        total++;
        if (ERR !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky: got %b want 1", ERR);
        end
    endtask

    task automatic test_reset_mid_busy;
        do_op(1'b1, 6'h03, 32'h11111111, 1'b0, "wr_03_pre");
        ADDRESS   = 6'h03;
        WRITEDATA = 32'h12345678;
        WRITE     = 1'b1;
        tick();
        WRITE = 1'b0;
        tick();
        RESET = 1'b0;
        tick();
        total++;
        if (READDATA !== 32'h0) begin
            bad++;
            $display("FAIL midrst_readdata: got %h want 00000000", READDATA);
        end
        total++;
        if (ERR !== 1'b0) begin
            bad++;
            $display("FAIL midrst_err: got %b want 0", ERR);
        end
        RESET = 1'b1;
`ifdef RESET_CLEAR_EN
        wait_clear("midrst");
`else
        total++;
        if (BUSYWAIT !== 1'b0) begin
            bad++;
            $display("FAIL midrst_busy: got %b want 0", BUSYWAIT);
        end
        for (int i = 0; i < LAT + 2; i++) tick();
        total++;
        if (BUSYWAIT !== 1'b0) begin
            bad++;
            $display("FAIL midrst_quiet: got %b want 0", BUSYWAIT);
        end
`endif
        do_op(1'b0, 6'h03, 32'h0, 1'b0, "rd_03_after_rst");
    endtask

    task automatic test_back_to_back;
        logic [5:0]  a;
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            a = 6'($urandom_range(0, 63));
            d = $urandom;
            do_op(1'b1, a, d, 1'b0, "b2b_wr");
            do_op(1'b0, a, 32'h0, 1'b0, "b2b_rd");
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            model[i] = 32'h0;
            valid[i] = 1'b0;
        end
        test_reset();
        test_write_read();
        test_hold_read();
        test_input_change();
        test_err();
        test_reset_mid_busy();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
